// File: rtl/iz_neuron_state_update.sv
// One Euler step of the approximate Izhikevich membrane/recovery update, driving an external squarer.
// Optional IZ_STATE_SAT_EN: saturate narrowed state to 16 bits instead of wrapping.
module iz_neuron_state_update #(
    parameter int C        = -65,
    parameter int D        = 8,
    parameter int V_PEAK   = 30,
    parameter int A_SHIFT  = 6,
    parameter int B_SHIFT  = 2,
    parameter int DT_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_valid,
    output logic        step_ready,
    input  logic [7:0]  i_in,
    output logic [7:0]  sq_x,
    input  logic [15:0] sq_in,
    output logic        out_valid,
    output logic [7:0]  v_out,
    output logic        spike
);

    localparam logic signed [15:0] V_RST    = 16'(C * 256);
    localparam logic signed [15:0] U_RST    = V_RST >>> B_SHIFT;
    localparam logic signed [23:0] D_Q      = 24'(D * 256);
    localparam logic signed [23:0] K140_Q   = 24'(140 * 256);
    localparam logic signed [7:0]  V_PEAK_S = 8'(V_PEAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic signed [15:0] r_v;
    logic signed [15:0] r_u;
    logic signed [7:0]  r_i;
    logic        [15:0] r_sq;
    logic               r_spike;
    logic               r_out_valid;

    logic               w_accept;
    logic signed [23:0] w_sq_e;
    logic signed [23:0] w_v_e;
    logic signed [23:0] w_u_e;
    logic signed [23:0] w_i_e;
    logic signed [23:0] w_dv;
    logic signed [23:0] w_v_new;
    logic signed [23:0] w_u_new;
    logic signed [15:0] w_v_nar;
    logic signed [15:0] w_u_nar;
    logic signed [15:0] w_u_spk;
    logic               w_fire;

    // Reduce a 24-bit intermediate to Q8.8 state width.
    function automatic logic signed [15:0] narrow16(input logic signed [23:0] x);
`ifdef IZ_STATE_SAT_EN
        if (x > 24'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -24'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
`else
        return x[15:0];
`endif
    endfunction

    assign step_ready = (r_state == ST_IDLE) && rst_n;
    assign w_accept   = step_valid && step_ready;
    assign sq_x       = r_v[15:8];
    assign v_out      = r_v[15:8];
    assign out_valid  = r_out_valid;
    assign spike      = r_spike;

    // Step arithmetic: 0.04*v^2 is approximated as (sq<<3)+(sq<<1) with sq an integer square.
    always_comb begin
        w_sq_e  = $signed({8'd0, r_sq});
        w_v_e   = {{8{r_v[15]}}, r_v};
        w_u_e   = {{8{r_u[15]}}, r_u};
        w_i_e   = {{16{r_i[7]}}, r_i};
        w_dv    = (w_sq_e <<< 3) + (w_sq_e <<< 1) + (w_v_e <<< 2) + w_v_e
                + K140_Q - w_u_e + (w_i_e <<< 8);
        w_v_new = w_v_e + (w_dv >>> DT_SHIFT);
        w_u_new = w_u_e + (((w_v_e >>> B_SHIFT) - w_u_e) >>> (A_SHIFT + DT_SHIFT));
        w_v_nar = narrow16(w_v_new);
        w_u_nar = narrow16(w_u_new);
        w_u_spk = narrow16(w_u_new + D_Q);
        w_fire  = ($signed(w_v_nar[15:8]) >= V_PEAK_S);
    end

    // Next-state logic for the four-phase step sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_SQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SQ:   w_next = ST_UPD;
            ST_UPD:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath registers: operand capture, state write-back and spike flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= V_RST;
            r_u     <= U_RST;
            r_i     <= 8'sd0;
            r_sq    <= 16'd0;
            r_spike <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_i <= i_in;
                    end
                end
                ST_SQ: begin
                    r_sq <= sq_in;
                end
                ST_UPD: begin
                    if (w_fire) begin
                        r_spike <= 1'b1;
                        r_v     <= V_RST;
                        r_u     <= w_u_spk;
                    end else begin
                        r_spike <= 1'b0;
                        r_v     <= w_v_nar;
                        r_u     <= w_u_nar;
                    end
                end
                default: begin
                    r_v <= r_v;
                end
            endcase
        end
    end

    // Result strobe, high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ST_UPD);
        end
    end

endmodule

// File: doc/iz_neuron_state_update.md
Name: iz_neuron_state_update

Overview:
- Sequential membrane/recovery update stage for the 20-neuron approximate Izhikevich datapath.
- Sits directly downstream of the 8-bit squaring circuit and also drives it:
  - presents integer membrane voltage on sq_x;
  - consumes the 16-bit square on sq_in;
  - computes one Euler step of v' = 0.04v² + 5v + 140 − u + I and u' = a(bv − u), with spike detection and reset.
- Held state: v and u, both signed Q8.8 (16 bit).

Parameters:
- C, -65: post-spike reset voltage, integer mV.
- D, 8: post-spike recovery increment, integer.
- V_PEAK, 30: spike threshold, integer mV; spike when integer part ≥ V_PEAK.
- A_SHIFT, 6: a ≈ 2^-A_SHIFT.
- B_SHIFT, 2: b ≈ 2^-B_SHIFT.
- DT_SHIFT, 0: dt = 2^-DT_SHIFT ms.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- step_valid  input  1  request one integration step.
- step_ready  output  1  step accepted when step_valid && step_ready.
- i_in  input  8  signed input current, integer; sampled on accept.
- sq_x  output  8  v_q[15:8], driven to the squarer's input.
- sq_in  input  16  squarer output, combinational from sq_x.
- out_valid  output  1  one-cycle pulse, step result valid.
- v_out  output  8  v_q[15:8] (floor integer mV).
- spike  output  1  spike flag for the completed step; valid with out_valid, held until the next out_valid.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - v_q = C<<8 = 0xBF00; u_q = (C<<8)>>>B_SHIFT = −4160 (0xEFC0).
  - out_valid = 0, spike = 0, step_ready = 0 while rst_n is low.
  - v_out = 0xBF (−65).
- FSM: IDLE → SQ → UPD → DONE → IDLE.
  - IDLE: step_ready = 1. On accept, latch i_in into i_q and go to SQ.
  - SQ: step_ready = 0; register sq_in into sq_q.
  - UPD: compute and write v_q/u_q, set spike.
  - DONE: out_valid = 1 for exactly one cycle.
- Latency: out_valid is asserted 3 cycles after the accept edge. Throughput is one step per 4 cycles.
- step_valid outside IDLE is ignored (not queued). It is accepted on the first IDLE cycle it is high.
- Arithmetic: 24-bit signed intermediates; all shifts arithmetic.
  - dv = (sq_q<<3) + (sq_q<<1) + 5·v_q + (140<<8) − u_q + (i_q<<8). The two sq_q terms give 0.0390625·sq in Q8.8.
  - v_new = v_q + (dv >>> DT_SHIFT).
  - u_new = u_q + (((v_q >>> B_SHIFT) − u_q) >>> (A_SHIFT + DT_SHIFT)), using the old v_q.
- Narrowing v_new to 16 bits: see Optional Feature.
- Spike: if narrowed v_new[15:8] ≥ V_PEAK (signed compare):
  - spike = 1;
  - v_q = C<<8;
  - u_q = u_new + (D<<8), narrowed the same way as v.
  - Otherwise spike = 0, v_q = v_new, u_q = u_new.
- sq_x tracks v_q continuously. The squarer's one's-complement approximation for negative inputs is accepted as-is.
- Reset in SQ/UPD/DONE aborts the step: no out_valid, and state returns to the reset values.

Optional Feature:
- Macro: IZ_STATE_SAT_EN.
- Defined: v_new, u_new and u_q + (D<<8) saturate to [−32768, 32767] on narrowing.
- Undefined: these values are truncated to their low 16 bits (two's-complement wrap). This gives smaller area, and the overflow is visible in the bench.

Test Plan:
- Reset, then step with i_in = 0, real squarer attached (sq_x = 0xBF → sq_in = 4096) → dv = −2240, v_q = −18880, v_out = 0xB6 (−74), u_q = −4160, spike = 0, out_valid on the 3rd cycle after accept.
- Reset, then step with i_in = 127 → dv = 30272, v_new = 13632 (53 ≥ 30) → spike = 1, v_q = 0xBF00, v_out = −65, u_q = −4160 + 2048 = −2112.
- Reset, then step with i_in = −128 → v_new = −51648:
  - with IZ_STATE_SAT_EN: v_q = −32768, v_out = 0x80, spike = 0;
  - without: wraps to 13888 (54) → spike = 1, v_q = 0xBF00.
- step_valid held high continuously from reset release → accepts exactly every 4th cycle; step_ready low in SQ/UPD/DONE; one out_valid per accept.
- Assert rst_n low during UPD → immediate v_out = 0xBF, out_valid never pulses for the aborted step; the next step reproduces the first scenario's result.
